// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter/rotator, one amount bit per stage, valid/ready on both sides
// Optional SHIFTER_PIPE_SRA_EN: op 100 is arithmetic right shift; otherwise op 100 behaves as SRL.
module shifter_pipe #(
  parameter int WIDTH = 16,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [AW-1:0]    vld;
  logic [AW-1:0]    ld;
  logic [WIDTH-1:0] dat   [AW];
  logic [AW-1:0]    amt_r [AW];
  logic [2:0]       op_r  [AW];
`ifdef SHIFTER_PIPE_SRA_EN
  logic             sgn_r [AW];
`endif

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin : load_chain
    logic acc;
    acc = out_ready;
    for (int k = AW - 1; k >= 0; k--) begin
      acc   = !vld[k] || acc;
      ld[k] = acc;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[AW-1];
  assign out_data  = dat[AW-1];

  for (genvar k = 0; k < AW; k++) begin : g_stage
    localparam int S = 1 << k;

    logic             s_vld;
    logic [WIDTH-1:0] s_dat;
    logic [AW-1:0]    s_amt;
    logic [2:0]       s_op;
    logic [WIDTH-1:0] moved;
`ifdef SHIFTER_PIPE_SRA_EN
    logic             s_sgn;
`endif

    if (k == 0) begin : g_src_in
      assign s_vld = in_valid;
      assign s_dat = in_data;
      assign s_amt = in_amt;
      assign s_op  = in_op;
`ifdef SHIFTER_PIPE_SRA_EN
      assign s_sgn = in_data[WIDTH-1];
`endif
    end else begin : g_src_prev
      assign s_vld = vld[k-1];
      assign s_dat = dat[k-1];
      assign s_amt = amt_r[k-1];
      assign s_op  = op_r[k-1];
`ifdef SHIFTER_PIPE_SRA_EN
      assign s_sgn = sgn_r[k-1];
`endif
    end

    always_comb begin
      moved = s_dat;
      if (s_amt[k]) begin
        case (s_op)
          3'b000:  moved = (s_dat << S) | (s_dat >> (WIDTH - S));
          3'b001:  moved = s_dat << S;
          3'b010:  moved = (s_dat >> S) | (s_dat << (WIDTH - S));
          3'b011:  moved = s_dat >> S;
`ifdef SHIFTER_PIPE_SRA_EN
          // Fill comes from the sign captured at entry, not the current top bit.
          3'b100:  moved = ({WIDTH{s_sgn}} << (WIDTH - S)) | (s_dat >> S);
`else
          3'b100:  moved = s_dat >> S;
`endif
          default: moved = s_dat;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld[k]   <= 1'b0;
        dat[k]   <= '0;
        amt_r[k] <= '0;
        op_r[k]  <= '0;
`ifdef SHIFTER_PIPE_SRA_EN
        sgn_r[k] <= 1'b0;
`endif
      end else if (ld[k]) begin
        vld[k]   <= s_vld;
        dat[k]   <= moved;
        amt_r[k] <= s_amt;
        op_r[k]  <= s_op;
`ifdef SHIFTER_PIPE_SRA_EN
        sgn_r[k] <= s_sgn;
`endif
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - self-checking bench for shifter_pipe at WIDTH=16
module tb_shifter_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [3:0]    in_amt = '0;
  logic [2:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;

  int            n_checks = 0;
  int            n_fail = 0;
  int            n_out = 0;
  logic [W-1:0]  q[$];
  logic          held = 1'b0;
  logic [W-1:0]  held_data = '0;

  shifter_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: rotates done one bit at a time, shifts with plain operators.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input int a, input int op);
    logic [W-1:0] r;
    r = d;
    case (op)
      0: for (int i = 0; i < a; i++) r = {r[W-2:0], r[W-1]};
      1: r = d << a;
      2: for (int i = 0; i < a; i++) r = {r[0], r[W-1:1]};
      3: r = d >> a;
`ifdef SHIFTER_PIPE_SRA_EN
      4: r = $signed(d) >>> a;
`else
      4: r = d >> a;
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  // Scoreboard: push on accept, pop on retire, and hold-stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall out_valid held", {31'b0, out_valid}, 32'd1);
        check("stall out_data held", {16'b0, out_data}, {16'b0, held_data});
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) check("spurious result", {16'b0, out_data}, 32'hFFFF_FFFF);
        else check("scoreboard result", {16'b0, out_data}, {16'b0, q.pop_front()});
      end
      if (in_valid && in_ready) q.push_back(ref_op(in_data, int'(in_amt), int'(in_op)));
      held      = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  task automatic run_one(input string name, input logic [W-1:0] d, input logic [3:0] a,
                         input logic [2:0] op, input logic [W-1:0] exp);
    int lat;
    logic got;
    in_data = d; in_amt = a; in_op = op; in_valid = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1'b1;
    end
    check({name, " latency"}, lat, 4);
    check(name, {16'b0, out_data}, {16'b0, exp});
  endtask

  task automatic randomize_in();
    in_data = W'($urandom);
    in_amt  = 4'($urandom_range(0, 15));
    in_op   = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int n0, stalls, acc, guard;
    logic t;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset out_valid", {31'b0, out_valid}, 0);
    check("reset out_data", {16'b0, out_data}, 0);
    check("reset in_ready", {31'b0, in_ready}, 1);

    run_one("ROR 8001>>1", 16'h8001, 4'd1, 3'b010, 16'hC000);
    run_one("ROL 1234<<4", 16'h1234, 4'd4, 3'b000, 16'h2341);
    run_one("SRL 8001>>4", 16'h8001, 4'd4, 3'b011, 16'h0800);
    run_one("SLL 0001<<15", 16'h0001, 4'd15, 3'b001, 16'h8000);
    for (int op = 0; op < 8; op++) run_one("amt0 A5A5", 16'hA5A5, 4'd0, 3'(op), 16'hA5A5);
    run_one("op110 BEEF", 16'hBEEF, 4'd7, 3'b110, 16'hBEEF);
`ifdef SHIFTER_PIPE_SRA_EN
    run_one("SRA 8000>>15", 16'h8000, 4'd15, 3'b100, 16'hFFFF);
`else
    run_one("SRA 8000>>15", 16'h8000, 4'd15, 3'b100, 16'h0001);
`endif
    run_one("SRA 4000>>2", 16'h4000, 4'd2, 3'b100, 16'h1000);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back stream at full rate.
    n0 = n_out; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      randomize_in();
      in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream stalls", stalls, 0);
    check("stream rate", n_out - n0, 16);
    repeat (5) @(posedge clk);
    #1;
    check("stream count", n_out - n0, 20);
    check("stream queue empty", q.size(), 0);

    // Back-pressure: 10 stalled cycles, then drain.
    n0 = n_out; acc = 0;
    out_ready = 1'b0;
    randomize_in();
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); t = in_ready;
      @(posedge clk); #1;
      if (t) begin acc++; randomize_in(); end
    end
    check("stall accepts", acc, 4);
    check("stall in_ready", {31'b0, in_ready}, 0);
    out_ready = 1'b1;
    guard = 0;
    while (acc < 8 && guard < 50) begin
      @(negedge clk); t = in_ready;
      @(posedge clk); #1;
      guard++;
      if (t) begin acc++; randomize_in(); end
    end
    in_valid = 1'b0;
    check("stall refill accepts", acc, 8);
    repeat (8) @(posedge clk);
    #1;
    check("drain count", n_out - n0, 8);
    check("drain queue empty", q.size(), 0);

    // Reset with three requests in flight.
    for (int i = 0; i < 3; i++) begin
      randomize_in();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post-reset out_valid", {31'b0, out_valid}, 0);
    check("post-reset in_ready", {31'b0, in_ready}, 1);
    n0 = n_out;
    run_one("post-reset ROL", 16'h1234, 4'd4, 3'b000, 16'h2341);
    run_one("post-reset SLL", 16'h0003, 4'd2, 3'b001, 16'h000C);
    repeat (4) @(posedge clk);
    #1;
    check("post-reset count", n_out - n0, 2);
    check("post-reset queue empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
